// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_pkg
// Description : Shared types for the pipeline stage registers: the stage FSM
//               state encoding, per-boundary payload structs whose $bits sets
//               the WIDTH of each pipe_stage_reg instance, and an occupancy
//               decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

  localparam int c_PIPE_OCC_W = 2;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,   // nothing held
    PS_HALF  = 2'd1,   // main register valid
    PS_FULL  = 2'd2    // main and skid registers valid
  } pipe_state_enum;

  // IF/ID boundary
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_payload_struct;

  // ID/EXE boundary
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } idexe_payload_struct;

  // EXE/MEM boundary
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exemem_payload_struct;

  // MEM/WB boundary
  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } memwb_payload_struct;

  // Number of held entries for a given state.
  function automatic logic [c_PIPE_OCC_W-1:0] pipe_occupancy(input pipe_state_enum s);
    case (s)
      PS_HALF: return 2'd1;
      PS_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Valid/ready handshake bundle around one pipeline stage
//               register: the upstream (in_*) and downstream (out_*) sides.
//               slave  - modport used by the stage register itself.
//               master - modport used by the surrounding pipeline / bench.
// Ports       : in_valid, in_ready, in_data[WIDTH], out_valid, out_ready,
//               out_data[WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_ctrl
// Description : Control FSM of pipe_stage_reg. Tracks how many entries are
//               held and produces the datapath load enables. Flush overrides
//               every transfer.
// Config      : PIPE_STAGE_REG_SKID_EN - two-entry skid buffer with a
//               registered in_ready; undefined gives a single register
//               whose in_ready depends combinationally on out_ready.
// Ports       : i_cpu_clk_50M, i_cpu_rst (async, active high), i_flush,
//               i_in_valid, i_out_ready -> o_in_ready, o_out_valid,
//               o_occupancy, o_load_main [, o_load_skid, o_move_skid]
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_ctrl
  import mips_cpu_pkg::*;
(
  input  wire logic                    i_cpu_clk_50M,
  input  wire logic                    i_cpu_rst,
  input  wire logic                    i_flush,
  input  wire logic                    i_in_valid,
  input  wire logic                    i_out_ready,
  output logic                         o_in_ready,
  output logic                         o_out_valid,
  output logic [c_PIPE_OCC_W-1:0]      o_occupancy,
`ifdef PIPE_STAGE_REG_SKID_EN
  output logic                         o_load_skid,
  output logic                         o_move_skid,
`endif
  output logic                         o_load_main
);

  pipe_state_enum              r_state;
  pipe_state_enum              w_state_nxt;
  logic                        r_out_valid;
  logic [c_PIPE_OCC_W-1:0]     r_occupancy;
  logic                        w_in_ready;
  logic                        w_in_xfer;
  logic                        w_out_xfer;
  logic                        w_load_main;
`ifdef PIPE_STAGE_REG_SKID_EN
  logic                        r_full;
  logic                        w_load_skid;
  logic                        w_move_skid;
`endif

`ifdef PIPE_STAGE_REG_SKID_EN
  // Pure decode of a flop: no path from out_ready to in_ready.
  assign w_in_ready = !i_cpu_rst && !r_full;
`else
  // Single register: may accept only if it is empty or draining this edge.
  assign w_in_ready = !i_cpu_rst && (!r_out_valid || i_out_ready);
`endif

  assign w_in_xfer  = i_in_valid && w_in_ready;
  assign w_out_xfer = r_out_valid && i_out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
    w_load_skid = 1'b0;
    w_move_skid = 1'b0;
`endif
    case (r_state)
      PS_EMPTY: begin
        if (w_in_xfer) begin
          w_load_main = 1'b1;
          w_state_nxt = PS_HALF;
        end
      end
      PS_HALF: begin
`ifdef PIPE_STAGE_REG_SKID_EN
        if (w_in_xfer && w_out_xfer) begin
          w_load_main = 1'b1;
        end else if (w_in_xfer) begin
          // Downstream stalled: park the new entry behind the held one.
          w_load_skid = 1'b1;
          w_state_nxt = PS_FULL;
        end else if (w_out_xfer) begin
          w_state_nxt = PS_EMPTY;
        end
`else
        // An accept here implies out_ready, so it is always a replace.
        if (w_in_xfer) begin
          w_load_main = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = PS_EMPTY;
        end
`endif
      end
`ifdef PIPE_STAGE_REG_SKID_EN
      PS_FULL: begin
        if (w_out_xfer) begin
          w_move_skid = 1'b1;
          w_state_nxt = PS_HALF;
        end
      end
`endif
      default: w_state_nxt = PS_EMPTY;
    endcase

    // Squash wins over any transfer; an input offered now is dropped.
    if (i_flush) begin
      w_state_nxt = PS_EMPTY;
      w_load_main = 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
      w_load_skid = 1'b0;
      w_move_skid = 1'b0;
`endif
    end
  end

  // State and its decoded outputs are all registered from the next state,
  // so they change together on the clock edge.
  always_ff @(posedge i_cpu_clk_50M or posedge i_cpu_rst) begin
    if (i_cpu_rst) begin
      r_state     <= PS_EMPTY;
      r_out_valid <= 1'b0;
      r_occupancy <= '0;
`ifdef PIPE_STAGE_REG_SKID_EN
      r_full      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != PS_EMPTY);
      r_occupancy <= pipe_occupancy(w_state_nxt);
`ifdef PIPE_STAGE_REG_SKID_EN
      r_full      <= (w_state_nxt == PS_FULL);
`endif
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_occupancy = r_occupancy;
  assign o_load_main = w_load_main;
`ifdef PIPE_STAGE_REG_SKID_EN
  assign o_load_skid = w_load_skid;
  assign o_move_skid = w_move_skid;
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic pipeline stage register with valid/ready handshake,
//               synchronous flush and an optional two-entry skid buffer.
//               Holds the payload datapath; control lives in pipe_stage_ctrl.
// Config      : PIPE_STAGE_REG_SKID_EN - adds skid register, registered
//               in_ready, occupancy up to 2. Undefined: single register,
//               occupancy up to 1.
// Parameters  : WIDTH (payload bits, >= 1), RESET_DATA (reset/flush value)
// Ports       : cpu_clk_50M, cpu_rst (async, active high), flush,
//               bus (pipe_stage_reg_if.slave: in_valid/in_ready/in_data,
//               out_valid/out_ready/out_data), occupancy[2]
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import mips_cpu_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  wire logic                cpu_clk_50M,
  input  wire logic                cpu_rst,
  input  wire logic                flush,
  pipe_stage_reg_if.slave          bus,
  output logic [c_PIPE_OCC_W-1:0]  occupancy
);

  logic [WIDTH-1:0] r_main_q;
  logic             w_load_main;
`ifdef PIPE_STAGE_REG_SKID_EN
  logic [WIDTH-1:0] r_skid_q;
  logic             w_load_skid;
  logic             w_move_skid;
`endif

  pipe_stage_ctrl u_ctrl (
    .i_cpu_clk_50M (cpu_clk_50M),
    .i_cpu_rst     (cpu_rst),
    .i_flush       (flush),
    .i_in_valid    (bus.in_valid),
    .i_out_ready   (bus.out_ready),
    .o_in_ready    (bus.in_ready),
    .o_out_valid   (bus.out_valid),
    .o_occupancy   (occupancy),
`ifdef PIPE_STAGE_REG_SKID_EN
    .o_load_skid   (w_load_skid),
    .o_move_skid   (w_move_skid),
`endif
    .o_load_main   (w_load_main)
  );

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_main_q <= RESET_DATA;
    end else if (flush) begin
      r_main_q <= RESET_DATA;
    end else if (w_load_main) begin
      r_main_q <= bus.in_data;
`ifdef PIPE_STAGE_REG_SKID_EN
    end else if (w_move_skid) begin
      // Older parked entry advances to the output on drain.
      r_main_q <= r_skid_q;
`endif
    end
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_skid_q <= RESET_DATA;
    end else if (flush) begin
      r_skid_q <= RESET_DATA;
    end else if (w_load_skid) begin
      r_skid_q <= bus.in_data;
    end
  end
`endif

  assign bus.out_data = r_main_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg. Covers
//               reset, streaming, simultaneous transfer, stall/back-pressure,
//               flush and mid-stream reset for the configuration selected by
//               PIPE_STAGE_REG_SKID_EN, plus a WIDTH=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] occ;
  logic [1:0] occ1;
  int         errors;
  int         checks;

  pipe_stage_reg_if #(.WIDTH(16)) bus ();
  pipe_stage_reg_if #(.WIDTH(1))  bus1 ();

  pipe_stage_reg #(.WIDTH(16), .RESET_DATA(16'hDEAD)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .flush       (flush),
    .bus         (bus),
    .occupancy   (occ)
  );

  pipe_stage_reg #(.WIDTH(1), .RESET_DATA(1'b1)) dut1 (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .flush       (flush),
    .bus         (bus1),
    .occupancy   (occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;

    // ---- reset state
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_occ",       occ, 0);
    chk("rst_in_ready",  bus.in_ready, 0);
    chk("rst_out_data",  bus.out_data, 16'hDEAD);
    chk("rst_w1_data",   bus1.out_data, 1);
    rst = 1'b0;
    #1;
    chk("rel_in_ready",  bus.in_ready, 1);

    // ---- streaming 1..8, one per cycle, no bubbles
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(i);
      tick();
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_data",  bus.out_data, i);
      chk("stream_ready", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", bus.out_valid, 0);
    chk("stream_drain_occ",   occ, 0);

    // ---- simultaneous in/out transfer in PS_HALF
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h5;
    tick();
    chk("sim_hold_occ",  occ, 1);
    chk("sim_hold_data", bus.out_data, 16'h5);
`ifdef PIPE_STAGE_REG_SKID_EN
    chk("sim_hold_ready", bus.in_ready, 1);
`else
    chk("sim_hold_ready", bus.in_ready, 0);
`endif
    bus.in_data   = 16'h6;
    bus.out_ready = 1'b1;
    #1;
    chk("sim_ready_up", bus.in_ready, 1);
    tick();
    chk("sim_data", bus.out_data, 16'h6);
    chk("sim_occ",  occ, 1);
    bus.in_valid = 1'b0;
    tick();
    chk("sim_drain_occ", occ, 0);

    // ---- stall / back-pressure, order A, B, C
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hA;
    tick();
    chk("stall_a_occ", occ, 1);
`ifdef PIPE_STAGE_REG_SKID_EN
    chk("stall_a_ready", bus.in_ready, 1);
    bus.in_data = 16'hB;
    tick();
    chk("stall_full_occ",   occ, 2);
    chk("stall_full_ready", bus.in_ready, 0);
    chk("stall_full_data",  bus.out_data, 16'hA);
    bus.in_data = 16'hC;
    tick();
    chk("stall_c_held_occ",  occ, 2);
    chk("stall_c_held_data", bus.out_data, 16'hA);
    bus.out_ready = 1'b1;
    tick();
    chk("stall_out_b",   bus.out_data, 16'hB);
    chk("stall_b_occ",   occ, 1);
    chk("stall_b_ready", bus.in_ready, 1);
`else
    chk("stall_a_ready", bus.in_ready, 0);
    bus.in_data = 16'hB;
    tick();
    chk("stall_b_held_occ",  occ, 1);
    chk("stall_b_held_data", bus.out_data, 16'hA);
    bus.out_ready = 1'b1;
    tick();
    chk("stall_out_b", bus.out_data, 16'hB);
    chk("stall_b_occ", occ, 1);
    bus.in_data = 16'hC;
`endif
    tick();
    chk("stall_out_c", bus.out_data, 16'hC);
    bus.in_valid = 1'b0;
    tick();
    chk("stall_drain_occ", occ, 0);

    // ---- flush while holding entries, with 0xF offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h11;
    tick();
`ifdef PIPE_STAGE_REG_SKID_EN
    bus.in_data = 16'h12;
    tick();
    chk("flush_pre_occ", occ, 2);
`else
    chk("flush_pre_occ", occ, 1);
    bus.out_ready = 1'b1;
`endif
    bus.in_data = 16'hF;
    flush = 1'b1;
    tick();
    chk("flush_occ",   occ, 0);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_data",  bus.out_data, 16'hDEAD);
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("flush_no_f", bus.out_valid, 0);

    // ---- asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h21;
    tick();
`ifdef PIPE_STAGE_REG_SKID_EN
    bus.in_data = 16'h22;
    tick();
    chk("mrst_pre_occ", occ, 2);
`else
    chk("mrst_pre_occ", occ, 1);
`endif
    rst = 1'b1;
    #1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_occ",   occ, 0);
    chk("mrst_ready", bus.in_ready, 0);
    chk("mrst_data",  bus.out_data, 16'hDEAD);
    tick();
    chk("mrst_held_occ", occ, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mrst_rel_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    tick();
    chk("mrst_no_emit", bus.out_valid, 0);

    // ---- WIDTH = 1 instance
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    bus1.in_data   = 1'b0;
    tick();
    chk("w1_data0",  bus1.out_data, 0);
    chk("w1_valid0", bus1.out_valid, 1);
    bus1.in_data = 1'b1;
    tick();
    chk("w1_data1", bus1.out_data, 1);
    chk("w1_occ",   occ1, 1);
    bus1.in_valid = 1'b0;
    tick();
    chk("w1_drain", bus1.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
